// File: rtl/window3x3_gen.sv
// Raster-stream 3x3 neighbourhood generator: two line buffers feed a 3x3
// shift window, and only windows lying fully inside the image are emitted.
module window3x3_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic              out_eof
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]     col, cur_col;
  logic [YW-1:0]     row, cur_row;
  logic              emit, last_pix;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] rd_top, rd_mid;
  logic [DATA_W-1:0] win_p0 [9];
  logic [DATA_W-1:0] nxt    [9];
  logic [DATA_W-1:0] pix_p1 [9];
  logic              vld_p1, eof_p1;
  logic [XW-1:0]     x_p1;
  logic [YW-1:0]     y_p1;

  // Stage 0: position of the current beat; in_sof forces it to (0,0)
  always_comb begin
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    emit     = in_valid && (cur_col >= XW'(2)) && (cur_row >= YW'(2));
    last_pix = (cur_col == X_LAST) && (cur_row == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (cur_col == X_LAST) begin
        col <= '0;
        row <= (cur_row == Y_LAST) ? '0 : cur_row + YW'(1);
      end else begin
        col <= cur_col + XW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers: old contents are read this beat, new ones land at the edge
  assign rd_top = lb1[cur_col];
  assign rd_mid = lb0[cur_col];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= in_pixel;
    end
  end

  // Window after this beat's shift: each row moves left, new column enters right
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nxt[3*r]   = win_p0[3*r+1];
      nxt[3*r+1] = win_p0[3*r+2];
    end
    nxt[2] = rd_top;
    nxt[5] = rd_mid;
    nxt[8] = in_pixel;
  end

  // Stage 1: shift window on every beat, capture outputs only on emitting beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      for (int i = 0; i < 9; i++) begin
        win_p0[i] <= '0;
        pix_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= emit;
      eof_p1 <= emit && last_pix;
      if (in_valid) win_p0 <= nxt;
      if (emit) begin
        pix_p1 <= nxt;
        x_p1   <= cur_col - XW'(1);
        y_p1   <= cur_row - YW'(1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_eof   = eof_p1;
  assign out_x     = x_p1;
  assign out_y     = y_p1;
  assign p0 = pix_p1[0];
  assign p1 = pix_p1[1];
  assign p2 = pix_p1[2];
  assign p3 = pix_p1[3];
  assign p4 = pix_p1[4];
  assign p5 = pix_p1[5];
  assign p6 = pix_p1[6];
  assign p7 = pix_p1[7];
  assign p8 = pix_p1[8];

endmodule
